// File: rtl/rv32i_debug_port_pkg.sv
// Shared definitions for the debug port: register offsets, UART states and
// STATUS bit positions.
package rv32i_debug_port_pkg;

  localparam logic [1:0] DBG_TOHOST   = 2'd0;
  localparam logic [1:0] DBG_CONSOLE  = 2'd1;
  localparam logic [1:0] DBG_STATUS   = 2'd2;
  localparam logic [1:0] DBG_RESERVED = 2'd3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_EXIT_VALID = 0;
  localparam int STAT_TX_BUSY    = 1;
  localparam int STAT_FIFO_EMPTY = 2;
  localparam int STAT_FIFO_FULL  = 3;
  localparam int STAT_COUNT_LSB  = 8;

  function automatic int clks_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/rv32i_debug_fifo.sv
// Byte FIFO with show-ahead read; pointers carry one extra bit so full and
// empty are told apart by the pointer MSB.
module rv32i_debug_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_count = wr_ptr - rd_ptr;
  assign o_data  = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define validity,
  // which keeps it mappable to plain RAM/flops without a reset network.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_debug_port.sv
// Wishbone debug responder: tohost exit capture, status readback and a
// FIFO-fed 8N1 console UART.
module rv32i_debug_port
  import rv32i_debug_port_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_uart_tx,
  output logic        o_exit_valid,
  output logic [30:0] o_exit_code
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       reg_sel;
  logic             accept;
  logic             wr_en;
  logic             ack_q;
  logic [31:0]      rd_data;
  logic [31:0]      status;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  uart_state_e      state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;

  logic unused_addr;
  assign unused_addr = ^{i_wb_addr[31:4], i_wb_addr[1:0]};

  assign reg_sel    = i_wb_addr[3:2];
  assign o_wb_stall = i_wb_stb & i_wb_we & (reg_sel == DBG_CONSOLE) & fifo_full;
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign wr_en      = accept & i_wb_we;
  assign fifo_push  = wr_en & (reg_sel == DBG_CONSOLE) & i_wb_sel[0];
  // A dropped cycle abandons the transfer, so the pending ack is masked.
  assign o_wb_ack   = ack_q & i_wb_cyc;

  rv32i_debug_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_data  (i_wb_data[7:0]),
    .i_pop   (fifo_pop),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    status                           = '0;
    status[STAT_EXIT_VALID]          = o_exit_valid;
    status[STAT_TX_BUSY]             = (state_q != UART_IDLE);
    status[STAT_FIFO_EMPTY]          = fifo_empty;
    status[STAT_FIFO_FULL]           = fifo_full;
    status[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      DBG_TOHOST: rd_data = {o_exit_code, o_exit_valid};
      DBG_STATUS: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q        <= 1'b0;
      o_wb_data    <= '0;
      o_exit_valid <= 1'b0;
      o_exit_code  <= '0;
    end else begin
      ack_q     <= accept;
      o_wb_data <= (accept && !i_wb_we) ? rd_data : '0;
      // Only the first passing/failing exit write is kept.
      if (wr_en && reg_sel == DBG_TOHOST && i_wb_sel == 4'hF &&
          i_wb_data[0] && !o_exit_valid) begin
        o_exit_valid <= 1'b1;
        o_exit_code  <= i_wb_data[31:1];
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    unique case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = UART_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_DATA: begin
        tx_d = shift_q[0];
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = UART_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          state_d = UART_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

  // The line is registered, so it trails the state by one clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= UART_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      o_uart_tx <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      o_uart_tx <= tx_d;
    end
  end

endmodule

// File: tb/tb_rv32i_debug_port.sv
// Directed bench for rv32i_debug_port at CLKS_PER_BIT=4 with a UART line
// monitor that decodes frames and records their start cycles.
module tb_rv32i_debug_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic [3:0]  wb_sel = '0;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_uart_tx;
  logic        o_exit_valid;
  logic [30:0] o_exit_code;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int ack_cnt = 0;
  int bad_frames = 0;
  logic [7:0] rx_q[$];
  int         st_q[$];

  logic [7:0] b2b [18] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'h81, 8'h3C,
                           8'hC3, 8'h0F, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

  rv32i_debug_port #(.CLK_FREQ_MHZ(1), .BAUD_RATE(250000), .FIFO_DEPTH(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wb_cyc     (wb_cyc),
    .i_wb_stb     (wb_stb),
    .i_wb_we      (wb_we),
    .i_wb_addr    (wb_addr),
    .i_wb_data    (wb_wdata),
    .i_wb_sel     (wb_sel),
    .o_wb_ack     (o_wb_ack),
    .o_wb_stall   (o_wb_stall),
    .o_wb_data    (o_wb_data),
    .o_uart_tx    (o_uart_tx),
    .o_exit_valid (o_exit_valid),
    .o_exit_code  (o_exit_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (o_wb_ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frame decoder: each bit must hold for all 4 clocks; aborted by reset.
  initial begin
    int s;
    logic bitv;
    logic ok;
    logic abort;
    logic [7:0] byte_v;
    forever begin
      @(negedge clk);
      if (rst_n && o_uart_tx == 1'b0) begin
        s = cyc_cnt; ok = 1'b1; abort = 1'b0; byte_v = '0; bitv = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < 4; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            if (c == 0) bitv = o_uart_tx;
            else if (o_uart_tx !== bitv) ok = 1'b0;
          end
          if (b == 0 && bitv !== 1'b0) ok = 1'b0;
          if (b == 9 && bitv !== 1'b1) ok = 1'b0;
          if (b >= 1 && b <= 8) byte_v[b-1] = bitv;
        end
        if (!abort) begin
          rx_q.push_back(byte_v);
          st_q.push_back(s);
          if (!ok) bad_frames++;
        end
      end
    end
  end

  task automatic wb_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel,
                           output logic [31:0] rdata, output int acc);
    int n;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = data; wb_sel = sel;
    n = 0;
    while (o_wb_stall && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_stall_timeout"}, o_wb_stall, 1'b0);
    @(posedge clk); #1;
    acc = cyc_cnt;
    wb_stb = 1'b0; wb_we = 1'b0;
    check({tag, "_ack"}, o_wb_ack, 1'b1);
    rdata = o_wb_data;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int acc;
    int a0;
    int n;
    int ack0;
    int lows;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", o_uart_tx, 1);
    check("rst_ack", o_wb_ack, 0);
    check("rst_exit_valid", o_exit_valid, 0);
    check("rst_exit_code", o_exit_code, 0);
    rst_n = 1'b1;
    wb_access("rst_status_rd", 0, 32'h8, 0, 4'hF, rd, acc);
    check("rst_status", rd, 32'h4);

    // Single console byte: start bit 2 clocks after acceptance
    wb_access("con41", 1, 32'h4, 32'h41, 4'hF, rd, acc);
    a0 = acc;
    wb_access("busy_rd", 0, 32'h8, 0, 4'hF, rd, acc);
    check("status_busy", rd, 32'h6);
    wait_rx("con41_rx_count", 1, 100);
    if (rx_q.size() >= 1) begin
      check("con41_byte", rx_q[0], 8'h41);
      check("con41_start_cycle", st_q[0], a0 + 2);
    end
    check("con41_frame_ok", bad_frames, 0);
    rx_q.delete(); st_q.delete();

    // 18 back-to-back console writes
    ack0 = ack_cnt;
    @(posedge clk); #1;
    wb_cyc = 1'b1;
    a0 = 0;
    for (int i = 0; i < 17; i++) begin
      wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 32'h4; wb_sel = 4'hF; wb_wdata = {24'h0, b2b[i]};
      check($sformatf("b2b_nostall_%0d", i), o_wb_stall, 0);
      @(posedge clk); #1;
      if (i == 0) a0 = cyc_cnt;
    end
    wb_wdata = {24'h0, b2b[17]};
    n = 0;
    while (o_wb_stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("b2b_stall_cycles", n, 26);
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    @(negedge clk);
    check("b2b_ack_count", ack_cnt - ack0, 18);
    wait_rx("b2b_rx_count", 18, 18 * 41 + 200);
    if (rx_q.size() == 18) begin
      check("b2b_first_start", st_q[0], a0 + 2);
      for (int k = 0; k < 18; k++) begin
        check($sformatf("b2b_byte_%0d", k), rx_q[k], b2b[k]);
        if (k > 0) check($sformatf("b2b_gap_%0d", k), st_q[k] - st_q[k-1], 41);
      end
    end
    check("b2b_frames_ok", bad_frames, 0);
    rx_q.delete(); st_q.delete();

    // TOHOST writes that must be ignored
    wb_access("th_bit0_clr", 1, 32'h0, 32'h6, 4'hF, rd, acc);
    check("th_bit0_clr_valid", o_exit_valid, 0);
    wb_access("th_partial_sel", 1, 32'h0, 32'h3, 4'h3, rd, acc);
    check("th_partial_sel_valid", o_exit_valid, 0);
    // Passing exit, then a later write must not change it
    wb_access("th_pass", 1, 32'h0, 32'h1, 4'hF, rd, acc);
    check("th_pass_valid", o_exit_valid, 1);
    check("th_pass_code", o_exit_code, 0);
    wb_access("th_second", 1, 32'h0, 32'h7, 4'hF, rd, acc);
    check("th_second_code", o_exit_code, 0);
    wb_access("th_rd", 0, 32'h0, 0, 4'hF, rd, acc);
    check("tohost_read", rd, 32'h1);
    wb_access("con_rd", 0, 32'h4, 0, 4'hF, rd, acc);
    check("console_read", rd, 32'h0);
    wb_access("rsv_wr", 1, 32'hC, 32'hFFFF_FFFF, 4'hF, rd, acc);
    wb_access("rsv_rd", 0, 32'hC, 0, 4'hF, rd, acc);
    check("reserved_read", rd, 32'h0);
    wb_access("con_nosel", 1, 32'h4, 32'h99, 4'hE, rd, acc);
    wb_access("exit_status_rd", 0, 32'h8, 0, 4'hF, rd, acc);
    check("status_exit_idle", rd, 32'h5);
    repeat (60) @(negedge clk);
    check("con_nosel_no_tx", rx_q.size(), 0);

    // Reset in the third data bit of a frame with a second byte queued
    rx_q.delete(); st_q.delete();
    wb_access("rst_con_a", 1, 32'h4, 32'h5A, 4'hF, rd, acc);
    a0 = acc;
    wb_access("rst_con_b", 1, 32'h4, 32'hAA, 4'hF, rd, acc);
    while (cyc_cnt < a0 + 15) @(negedge clk);
    check("mid_frame_tx_bit2", o_uart_tx, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", o_uart_tx, 1);
    check("async_rst_ack", o_wb_ack, 0);
    check("async_rst_exit_valid", o_exit_valid, 0);
    check("async_rst_exit_code", o_exit_code, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb_access("post_rst_status_rd", 0, 32'h8, 0, 4'hF, rd, acc);
    check("post_rst_status", rd, 32'h4);
    lows = 0;
    repeat (120) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1) lows++;
    end
    check("post_rst_line_idle", lows, 0);
    check("post_rst_no_rx", rx_q.size(), 0);

    // Failing exit code after reset
    wb_access("th_fail", 1, 32'h0, 32'h2B, 4'hF, rd, acc);
    check("th_fail_valid", o_exit_valid, 1);
    check("th_fail_code", o_exit_code, 32'h15);
    wb_access("th_fail_rd", 0, 32'h0, 0, 4'hF, rd, acc);
    check("th_fail_read", rd, 32'h2B);
    check("all_frames_ok", bad_frames, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
